// File: rtl/sipo_40.sv
// Serial-to-parallel receiver: reassembles a sync-framed bit stream into WIDTH-bit words
// and presents them through a single-entry valid/ready holding register.
module sipo_40 #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             clock_40,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             bit_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy,
  output logic             frame_error,
  output logic             overrun
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           r_state;
  logic [CntW-1:0]  r_count;
  logic [WIDTH-1:0] r_shift;

  logic [WIDTH-1:0] w_word_start;
  logic [WIDTH-1:0] w_word_next;
  logic             w_last;
  logic             w_complete;

  // w_word_start: a fresh word holding only the incoming bit as bit 0.
  // w_word_next: the partial word with the incoming bit placed at position r_count.
  always_comb begin
    w_word_start = '0;
    w_word_next  = r_shift;
    if (LSB_FIRST) begin
      w_word_start[0]       = serial_in;
      w_word_next[r_count]  = serial_in;
    end else begin
      w_word_start[WIDTH-1]                   = serial_in;
      w_word_next[CntW'(WIDTH-1) - r_count]   = serial_in;
    end
  end

  assign w_last     = (r_count == CntW'(WIDTH-1));
  assign w_complete = bit_valid && !sync && (r_state == StShift) && w_last;
  assign busy       = (r_state == StShift);

  always_ff @(posedge clock_40 or negedge reset) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_count     <= '0;
      r_shift     <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      overrun     <= 1'b0;

      if (bit_valid) begin
        case (r_state)
          StIdle: begin
            if (sync) begin
              r_shift <= w_word_start;
              r_count <= CntW'(1);
              r_state <= StShift;
            end
          end
          StShift: begin
            if (sync) begin
              frame_error <= 1'b1;
              r_shift     <= w_word_start;
              r_count     <= CntW'(1);
            end else if (w_last) begin
              r_shift <= w_word_next;
              r_count <= '0;
              r_state <= StIdle;
            end else begin
              r_shift <= w_word_next;
              r_count <= r_count + CntW'(1);
            end
          end
          default: r_state <= StIdle;
        endcase
      end

      // A full holding register that is not being drained drops the new word.
      if (w_complete) begin
        if (!data_valid || data_ready) begin
          data_out   <= w_word_next;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_40.sv
// Scoreboard bench for sipo_40: one LSB-first and one MSB-first instance share the stimulus.
module tb_sipo_40;

  logic       clock_40;
  logic       reset;
  logic       serial_in;
  logic       bit_valid;
  logic       sync;
  logic       data_ready;

  logic [7:0] a_out, b_out;
  logic       a_valid, b_valid, a_busy, b_busy, a_fe, b_fe, a_ov, b_ov;

  int checks;
  int failures;

  logic [7:0] qa[$];
  logic [7:0] qb[$];

  sipo_40 #(.WIDTH(8), .LSB_FIRST(1'b1)) u_dut_lsb (
    .clock_40   (clock_40),
    .reset      (reset),
    .serial_in  (serial_in),
    .bit_valid  (bit_valid),
    .sync       (sync),
    .data_out   (a_out),
    .data_valid (a_valid),
    .data_ready (data_ready),
    .busy       (a_busy),
    .frame_error(a_fe),
    .overrun    (a_ov)
  );

  sipo_40 #(.WIDTH(8), .LSB_FIRST(1'b0)) u_dut_msb (
    .clock_40   (clock_40),
    .reset      (reset),
    .serial_in  (serial_in),
    .bit_valid  (bit_valid),
    .sync       (sync),
    .data_out   (b_out),
    .data_valid (b_valid),
    .data_ready (data_ready),
    .busy       (b_busy),
    .frame_error(b_fe),
    .overrun    (b_ov)
  );

  initial clock_40 = 1'b0;
  always #5 clock_40 = ~clock_40;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  task automatic tick(input logic v, input logic s, input logic b);
    bit_valid = v;
    sync      = s;
    serial_in = b;
    @(posedge clock_40);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w, input int gap, input bit push);
    if (push) begin
      qa.push_back(w);
      qb.push_back(rev8(w));
    end
    for (int k = 0; k < 8; k++) begin
      tick(1'b1, (k == 0), w[k]);
      for (int g = 0; g < gap; g++) begin
        tick(1'b0, 1'b0, 1'b0);
        if (k < 7) chk("gap_busy", a_busy, 1'b1);
      end
    end
  endtask

  // Monitor: a newly presented word is one where valid rose or a handshake just completed.
  logic       pa_valid, pa_hs, pb_valid, pb_hs;
  logic [7:0] held_a, held_b;

  always @(negedge clock_40) begin
    if (!reset) begin
      pa_valid <= 1'b0;
      pa_hs    <= 1'b0;
    end else begin
      if (a_valid && (!pa_valid || pa_hs)) begin
        if (qa.size() == 0) chk("lsb_unexpected_word", a_out, 32'hFFFF_FFFF);
        else chk("lsb_word", a_out, qa.pop_front());
        held_a <= a_out;
      end else if (a_valid) begin
        chk("lsb_hold", a_out, held_a);
      end
      pa_valid <= a_valid;
      pa_hs    <= a_valid && data_ready;
    end
  end

  always @(negedge clock_40) begin
    if (!reset) begin
      pb_valid <= 1'b0;
      pb_hs    <= 1'b0;
    end else begin
      if (b_valid && (!pb_valid || pb_hs)) begin
        if (qb.size() == 0) chk("msb_unexpected_word", b_out, 32'hFFFF_FFFF);
        else chk("msb_word", b_out, qb.pop_front());
        held_b <= b_out;
      end else if (b_valid) begin
        chk("msb_hold", b_out, held_b);
      end
      pb_valid <= b_valid;
      pb_hs    <= b_valid && data_ready;
    end
  end

  logic [7:0] w;

  initial begin
    checks     = 0;
    failures   = 0;
    reset      = 1'b0;
    serial_in  = 1'b0;
    bit_valid  = 1'b0;
    sync       = 1'b0;
    data_ready = 1'b1;
    #3;
    chk("rst_data_out", a_out, 8'h00);
    chk("rst_valid", a_valid, 1'b0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_fe", a_fe, 1'b0);
    chk("rst_ov", a_ov, 1'b0);
    @(posedge clock_40);
    @(posedge clock_40);
    #1;
    reset = 1'b1;
    tick(1'b0, 1'b0, 1'b0);

    // 0xA5 with bit_valid held high: exact latency and busy profile
    w = 8'hA5;
    qa.push_back(w);
    qb.push_back(rev8(w));
    for (int k = 0; k < 8; k++) begin
      tick(1'b1, (k == 0), w[k]);
      if (k < 7) begin
        chk("a5_busy", a_busy, 1'b1);
        chk("a5_valid_early", a_valid, 1'b0);
      end else begin
        chk("a5_busy_end", a_busy, 1'b0);
        chk("a5_valid", a_valid, 1'b1);
        chk("a5_data", a_out, 8'hA5);
      end
    end
    tick(1'b0, 1'b0, 1'b0);
    chk("a5_consumed", a_valid, 1'b0);

    // 0x3C with 3-cycle gaps
    send_word(8'h3C, 3, 1'b1);
    chk("3c_data", a_out, 8'h3C);

    // Aborted fragment 1,1,1 then synced 0x81
    w = 8'h81;
    qa.push_back(w);
    qb.push_back(rev8(w));
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    chk("abort_no_fe_yet", a_fe, 1'b0);
    tick(1'b1, 1'b1, w[0]);
    chk("abort_fe", a_fe, 1'b1);
    chk("abort_fe_msb", b_fe, 1'b1);
    chk("abort_busy", a_busy, 1'b1);
    for (int k = 1; k < 8; k++) begin
      tick(1'b1, 1'b0, w[k]);
      if (k == 1) chk("abort_fe_pulse", a_fe, 1'b0);
    end
    chk("81_data", a_out, 8'h81);
    tick(1'b0, 1'b0, 1'b0);

    // Overrun: 0x11 held, 0x22 dropped
    data_ready = 1'b0;
    send_word(8'h11, 0, 1'b1);
    chk("ov_first_valid", a_valid, 1'b1);
    send_word(8'h22, 0, 1'b0);
    chk("ov_pulse", a_ov, 1'b1);
    chk("ov_pulse_msb", b_ov, 1'b1);
    chk("ov_data_kept", a_out, 8'h11);
    tick(1'b0, 1'b0, 1'b0);
    chk("ov_pulse_end", a_ov, 1'b0);
    chk("ov_still_valid", a_valid, 1'b1);
    data_ready = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    chk("ov_drained", a_valid, 1'b0);
    chk("ov_data_after", a_out, 8'h11);

    // Reset mid-word
    tick(1'b1, 1'b1, 1'b1);
    for (int k = 1; k < 5; k++) tick(1'b1, 1'b0, 1'b1);
    chk("pre_rst_busy", a_busy, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_data", a_out, 8'h00);
    chk("async_rst_busy", a_busy, 1'b0);
    chk("async_rst_valid", a_valid, 1'b0);
    chk("async_rst_msb_data", b_out, 8'h00);
    @(posedge clock_40);
    @(posedge clock_40);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 1'b0, 1'b1);
      chk("nosync_busy", a_busy, 1'b0);
      chk("nosync_valid", a_valid, 1'b0);
    end
    send_word(8'h5A, 0, 1'b1);
    chk("5a_data", a_out, 8'h5A);

    // MSB-first placement
    send_word(8'h01, 0, 1'b1);
    chk("msb_first_data", b_out, 8'h80);
    chk("lsb_first_data", a_out, 8'h01);

    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0);
    chk("lsb_queue_empty", qa.size(), 0);
    chk("msb_queue_empty", qb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sipo_40.md
# sipo_40

Serial-to-parallel receiver for the 40 MHz serial link. It takes the 1-bit stream produced by the 8-bit parallel-to-serial shifter, LSB first, and reassembles it into WIDTH-bit words. A sync qualifier aligns word boundaries, and completed words go out through a single-entry valid/ready holding register. It sits at the far end of the link, feeding downstream parallel logic in the same clock_40 domain.

## Interface
- WIDTH, 8, word width in bits; legal range 2..32.
- LSB_FIRST, 1, 1: the first received bit lands in data_out[0]; 0: the first received bit lands in data_out[WIDTH-1].

- clock_40  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- serial_in  in  1  serial data bit; sampled only when bit_valid=1.
- bit_valid  in  1  qualifies serial_in this cycle.
- sync  in  1  marks the sampled bit as bit 0 of a new word; ignored when bit_valid=0.
- data_out  out  WIDTH  last completed word; held stable while data_valid=1.
- data_valid  out  1  high while the holding register contains an unconsumed word.
- data_ready  in  1  consumer accepts data_out when data_valid and data_ready are both 1 at a rising edge.
- busy  out  1  high while a partial word is being assembled (state SHIFT).
- frame_error  out  1  one-cycle pulse: a partial word was aborted by sync.
- overrun  out  1  one-cycle pulse: a completed word was dropped because the holding register was full.

## Operation
- Reset values: data_out=0, data_valid=0, busy=0, frame_error=0, overrun=0, state=IDLE, bit count=0, shift register=0.
- Sampling rule: a bit is accepted on a rising edge where bit_valid=1. Cycles with bit_valid=0 change nothing in the assembler, so gaps of any length are allowed.
- State IDLE:
  - An accepted bit with sync=1 is stored as bit 0, count becomes 1, and the state moves to SHIFT.
  - An accepted bit with sync=0 is discarded.
- State SHIFT:
  - Each accepted bit with sync=0 is stored at position count, and count increments.
  - When the accepted bit is bit WIDTH-1, the word is complete. The completed word is offered to the holding register and the state returns to IDLE. There is no implicit back-to-back framing: every word needs its own sync.
  - An accepted bit with sync=1 aborts the partial word: frame_error pulses, the new bit becomes bit 0, count becomes 1, and the state stays SHIFT.
- Bit placement: with LSB_FIRST=1, bit k goes to data_out[k]. With LSB_FIRST=0, bit k goes to data_out[WIDTH-1-k].
- Holding register, on a completion edge:
  - If data_valid=0, or data_valid=1 with data_ready=1: data_out is loaded with the new word and data_valid is 1 after the edge.
  - If data_valid=1 with data_ready=0: the new word is dropped, data_out is unchanged, and overrun pulses.
- Consumption: data_valid=1 and data_ready=1 with no completion on the same edge clears data_valid. data_out keeps its last value.
- busy equals (state == SHIFT).
- WIDTH=1 is not supported.

## Timing
- Latency: the rising edge that samples bit WIDTH-1 also registers data_out and sets data_valid. The word is therefore visible in the following cycle, 0 cycles of added delay.
- Minimum word period is WIDTH cycles (bit_valid held high, sync on the first bit). Back-to-back words are sustained with data_ready=1.
- frame_error and overrun are high for exactly the one cycle following the causing edge.
- Reset is asserted asynchronously and forces all outputs to their reset values immediately. Deassertion must be synchronous to clock_40 externally. A partial word in progress is discarded, and the first post-reset word needs sync.

## Test plan
- Word 0xA5, LSB_FIRST=1: bits 1,0,1,0,0,1,0,1 with sync on the first bit and bit_valid held high. Required: data_out=0xA5 and data_valid=1 in the cycle after the 8th bit edge; busy high for the cycles between.
- Word 0x3C with bit_valid=0 gaps of 3 cycles between bits. Required: data_out=0x3C, with no change to state or count during the gaps.
- Bits 1,1,1 of a word, then sync on a new word 0x81. Required: one frame_error pulse at the 4th bit edge, then data_out=0x81; no word emitted for the aborted fragment.
- Words 0x11 then 0x22 back-to-back with data_ready=0. Required: data_out stays 0x11, data_valid=1, one overrun pulse at 0x22 completion. Then raise data_ready for one cycle: data_valid drops.
- Start word 0xFF and assert reset after 5 bits. Required: all outputs 0 immediately. After release, bits without sync are ignored, and a synced 0x5A yields data_out=0x5A.
- LSB_FIRST=0: serial bits 1,0,0,0,0,0,0,0 with sync on the first. Required: data_out=0x80.
